// File: rtl/fft_r22sdf_pkg.sv
// Shared helpers for the R2^2 SDF FFT pipeline: index math, twiddle values and
// the round-then-saturate step applied after each fixed-point multiply.
package fft_r22sdf_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic [1:0] br2(input logic [1:0] b);
        return {b[0], b[1]};
    endfunction

    // Local transform size seen by the twiddle after butterfly stage `stage`.
    function automatic int stage_lw(input int nlog2, input int stage);
        return nlog2 - 2 * stage;
    endfunction

    function automatic int stage_l(input int nlog2, input int stage);
        return 1 << stage_lw(nlog2, stage);
    endfunction

    // Add half an LSB, floor-shift, then clamp into a signed `width`-bit range.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] value,
                                                     input int shift, input int width);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (value + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (r > hi) r = hi;
        else if (r < lo) r = lo;
        return r;
    endfunction

    // Round half away from zero; only ever evaluated on constants.
    function automatic int tw_round(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

    function automatic int tw_re(input int e, input int l, input int tw_width);
        real ang;
        ang = 2.0 * 3.14159265358979323846 * real'(e) / real'(l);
        return tw_round($cos(ang) * (2.0 ** (tw_width - 2)));
    endfunction

    function automatic int tw_im(input int e, input int l, input int tw_width);
        real ang;
        ang = 2.0 * 3.14159265358979323846 * real'(e) / real'(l);
        return -tw_round($sin(ang) * (2.0 ** (tw_width - 2)));
    endfunction

endpackage

// File: rtl/fft_r22sdf_tw_rom.sv
// Twiddle ROM holding W_L^e for e = 0..L-1 in Q1.(TW_WIDTH-2), one-cycle registered read.
module fft_r22sdf_tw_rom
    import fft_r22sdf_pkg::*;
#(
    parameter int L        = 1024,
    parameter int TW_WIDTH = 25
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic [clog2(L)-1:0]        addr_i,
    output logic signed [TW_WIDTH-1:0] tw_re_o,
    output logic signed [TW_WIDTH-1:0] tw_im_o
);

    logic signed [TW_WIDTH-1:0] rom_re [L];
    logic signed [TW_WIDTH-1:0] rom_im [L];

    // Table contents are constants folded at elaboration.
    for (genvar i = 0; i < L; i++) begin : g_rom
        assign rom_re[i] = TW_WIDTH'(tw_re(i, L, TW_WIDTH));
        assign rom_im[i] = TW_WIDTH'(tw_im(i, L, TW_WIDTH));
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tw_re_o <= '0;
            tw_im_o <= '0;
        end else begin
            tw_re_o <= rom_re[addr_i];
            tw_im_o <= rom_im[addr_i];
        end
    end

endmodule

// File: rtl/fft_r22sdf_tw_mult.sv
// Twiddle multiplier between R2^2 SDF butterfly stages STAGE and STAGE+1.
// Four-cycle pipeline: exponent, ROM read, partial products, combine/round/saturate.
module fft_r22sdf_tw_mult
    import fft_r22sdf_pkg::*;
#(
    parameter int DATA_WIDTH = 25,
    parameter int TW_WIDTH   = 25,
    parameter int FFT_N      = 1024,
    parameter int FFT_NLOG2  = 10,
    parameter int STAGE      = 0,
    parameter int STAGES     = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         valid_i,
    input  logic [FFT_NLOG2-1:0]         cnt_i,
    input  logic signed [DATA_WIDTH-1:0] x_re_i,
    input  logic signed [DATA_WIDTH-1:0] x_im_i,
    output logic                         valid_o,
    output logic [FFT_NLOG2-1:0]         cnt_o,
    output logic signed [DATA_WIDTH-1:0] z_re_o,
    output logic signed [DATA_WIDTH-1:0] z_im_o
);

    localparam int LW = stage_lw(FFT_NLOG2, STAGE);
    localparam int L  = stage_l(FFT_NLOG2, STAGE);
    localparam int PW = DATA_WIDTH + TW_WIDTH;
    localparam int SW = PW + 1;

    if (STAGE >= STAGES - 1) begin : g_bad_stage
        $error("fft_r22sdf_tw_mult: last stage has only unity twiddles, STAGE must be < STAGES-1");
    end
    if (FFT_N != (1 << FFT_NLOG2)) begin : g_bad_n
        $error("fft_r22sdf_tw_mult: FFT_N must equal 2**FFT_NLOG2");
    end

    // Exponent e = m * bitrev(b) never exceeds 3*(L/4-1), so LW bits suffice.
    logic [1:0]    b;
    logic [LW-3:0] m;
    logic [LW-1:0] e_d;

    assign b   = cnt_i[LW-1 -: 2];
    assign m   = cnt_i[LW-3:0];
    assign e_d = LW'(m) * LW'(br2(b));

    logic [LW-1:0]                e1_q;
    logic signed [DATA_WIDTH-1:0] xr1_q, xi1_q, xr2_q, xi2_q;
    logic [FFT_NLOG2-1:0]         cnt1_q, cnt2_q, cnt3_q, cnt4_q;
    logic                         v1_q, v2_q, v3_q, v4_q;
    logic signed [TW_WIDTH-1:0]   tw_re, tw_im;
    logic signed [PW-1:0]         p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [SW-1:0]         re_sum, im_sum;
    logic signed [DATA_WIDTH-1:0] zr_d, zi_d, zr_q, zi_q;

    fft_r22sdf_tw_rom #(
        .L        (L),
        .TW_WIDTH (TW_WIDTH)
    ) u_rom (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .addr_i  (e1_q),
        .tw_re_o (tw_re),
        .tw_im_o (tw_im)
    );

    // Valid and counter shift every cycle; data only moves with its valid.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            v4_q   <= 1'b0;
            cnt1_q <= '0;
            cnt2_q <= '0;
            cnt3_q <= '0;
            cnt4_q <= '0;
        end else begin
            v1_q   <= valid_i;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            v4_q   <= v3_q;
            cnt1_q <= cnt_i;
            cnt2_q <= cnt1_q;
            cnt3_q <= cnt2_q;
            cnt4_q <= cnt3_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            e1_q  <= '0;
            xr1_q <= '0;
            xi1_q <= '0;
            xr2_q <= '0;
            xi2_q <= '0;
        end else begin
            if (valid_i) begin
                e1_q  <= e_d;
                xr1_q <= x_re_i;
                xi1_q <= x_im_i;
            end
            if (v1_q) begin
                xr2_q <= xr1_q;
                xi2_q <= xi1_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
        end else if (v2_q) begin
            p_rr_q <= PW'(xr2_q) * PW'(tw_re);
            p_ii_q <= PW'(xi2_q) * PW'(tw_im);
            p_ri_q <= PW'(xr2_q) * PW'(tw_im);
            p_ir_q <= PW'(xi2_q) * PW'(tw_re);
        end
    end

    always_comb begin
        re_sum = SW'(p_rr_q) - SW'(p_ii_q);
        im_sum = SW'(p_ri_q) + SW'(p_ir_q);
        zr_d   = DATA_WIDTH'(sat_round(64'(re_sum), TW_WIDTH - 2, DATA_WIDTH));
        zi_d   = DATA_WIDTH'(sat_round(64'(im_sum), TW_WIDTH - 2, DATA_WIDTH));
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            zr_q <= '0;
            zi_q <= '0;
        end else if (v3_q) begin
            zr_q <= zr_d;
            zi_q <= zi_d;
        end
    end

    assign valid_o = v4_q;
    assign cnt_o   = cnt4_q;
    assign z_re_o  = zr_q;
    assign z_im_o  = zi_q;

endmodule

// File: tb/tb_fft_r22sdf_tw_mult.sv
// Randomized bench for fft_r22sdf_tw_mult (STAGE=0, N=1024) against a behavioural model.
module tb_fft_r22sdf_tw_mult;

    localparam int DW    = 25;
    localparam int TW    = 25;
    localparam int N     = 1024;
    localparam int NLOG2 = 10;

    logic                 clk_i   = 1'b0;
    logic                 rst_n   = 1'b1;
    logic                 valid_i = 1'b0;
    logic [NLOG2-1:0]     cnt_i   = '0;
    logic signed [DW-1:0] x_re_i  = '0;
    logic signed [DW-1:0] x_im_i  = '0;
    logic                 valid_o;
    logic [NLOG2-1:0]     cnt_o;
    logic signed [DW-1:0] z_re_o;
    logic signed [DW-1:0] z_im_o;

    always #5 clk_i = ~clk_i;

    fft_r22sdf_tw_mult #(
        .DATA_WIDTH (DW),
        .TW_WIDTH   (TW),
        .FFT_N      (N),
        .FFT_NLOG2  (NLOG2),
        .STAGE      (0),
        .STAGES     (5)
    ) dut (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .cnt_i   (cnt_i),
        .x_re_i  (x_re_i),
        .x_im_i  (x_im_i),
        .valid_o (valid_o),
        .cnt_o   (cnt_o),
        .z_re_o  (z_re_o),
        .z_im_o  (z_im_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int brv(input int b);
        case (b)
            0:       return 0;
            1:       return 2;
            2:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int exponent(input int cnt);
        int k;
        k = cnt % N;
        return (k % (N / 4)) * brv(k / (N / 4));
    endfunction

    function automatic longint round_away(input real v);
        if (v >= 0.0) return longint'($floor(v + 0.5));
        return -longint'($floor(0.5 - v));
    endfunction

    function automatic void twiddle(input int e, output longint wr, output longint wi);
        real a;
        a  = 2.0 * 3.14159265358979323846 * real'(e) / real'(N);
        wr = round_away($cos(a) * (2.0 ** (TW - 2)));
        wi = -round_away($sin(a) * (2.0 ** (TW - 2)));
    endfunction

    function automatic longint rnd_sat(input longint v);
        longint r;
        longint hi;
        r  = (v + (64'sd1 <<< (TW - 3))) >>> (TW - 2);
        hi = (64'sd1 <<< (DW - 1)) - 1;
        if (r > hi) r = hi;
        if (r < -hi - 1) r = -hi - 1;
        return r;
    endfunction

    function automatic void model(input int cnt, input longint xr, input longint xi,
                                  output longint zr, output longint zi);
        longint wr;
        longint wi;
        twiddle(exponent(cnt), wr, wi);
        zr = rnd_sat(xr * wr - xi * wi);
        zi = rnd_sat(xr * wi + xi * wr);
    endfunction

    // ---------------- input history and per-cycle compare ----------------
    typedef struct {
        bit     v;
        int     cnt;
        longint xr;
        longint xi;
    } ent_t;

    ent_t   hist[$];
    ent_t   en;
    bit     ev;
    longint zr_hold = 0;
    longint zi_hold = 0;

    always @(posedge clk_i) begin
        if (rst_n) begin
            hist.push_back('{valid_i, int'(cnt_i), longint'(x_re_i), longint'(x_im_i)});
            if (hist.size() > 8) void'(hist.pop_front());
        end
    end

    always @(negedge rst_n) begin
        hist.delete();
        zr_hold = 0;
        zi_hold = 0;
    end

    always @(negedge clk_i) begin
        if (!rst_n) begin
            chk("reset_valid", longint'(valid_o), 0);
            chk("reset_cnt", longint'(cnt_o), 0);
            chk("reset_re", longint'(z_re_o), 0);
            chk("reset_im", longint'(z_im_o), 0);
        end else begin
            ev = 1'b0;
            if (hist.size() >= 4) begin
                en = hist[hist.size() - 4];
                ev = en.v;
            end
            chk("valid_o", longint'(valid_o), longint'(ev));
            if (ev) begin
                model(en.cnt, en.xr, en.xi, zr_hold, zi_hold);
                chk("cnt_o", longint'(cnt_o), longint'(en.cnt));
            end
            chk("z_re", longint'(z_re_o), zr_hold);
            chk("z_im", longint'(z_im_o), zi_hold);
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; holds the inputs for exactly one capturing edge.
    task automatic send(input bit v, input int cnt, input longint xr, input longint xi);
        valid_i = v;
        cnt_i   = NLOG2'(cnt);
        x_re_i  = DW'(xr);
        x_im_i  = DW'(xi);
        @(posedge clk_i);
        #1;
    endtask

    function automatic longint rnd_data();
        if ($urandom_range(0, 15) == 0) return -(64'sd1 <<< (DW - 1));
        return longint'($urandom_range(0, (1 << DW) - 1)) - (64'sd1 <<< (DW - 1));
    endfunction

    task automatic directed(input string name, input int cnt, input longint xr, input longint xi,
                            input longint er, input longint ei);
        send(1'b1, cnt, xr, xi);
        repeat (3) send(1'b0, 0, rnd_data(), rnd_data());
        #1;
        chk({name, "_valid"}, longint'(valid_o), 1);
        chk({name, "_cnt"}, longint'(cnt_o), longint'(cnt));
        chk({name, "_re"}, longint'(z_re_o), er);
        chk({name, "_im"}, longint'(z_im_o), ei);
        #0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        longint pr, pi, wr, wi;
        bit     gaps[7];
        int     cnt;
        int     nval;

        // Pin the model against hand-computed values.
        twiddle(128, wr, wi);
        chk("pin_tw128_re", wr, 5931642);
        chk("pin_tw128_im", wi, -5931642);
        model(5, 1000, -500, pr, pi);
        chk("pin_id_re", pr, 1000);
        chk("pin_id_im", pi, -500);
        model(384, 1000, 0, pr, pi);
        chk("pin_mj_re", pr, 0);
        chk("pin_mj_im", pi, -1000);
        model(640, -(64'sd1 <<< 24), -(64'sd1 <<< 24), pr, pi);
        chk("pin_sat_re", pr, -(64'sd1 <<< 24));
        chk("pin_sat_im", pi, 0);

        #2 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        @(posedge clk_i);
        #1;

        directed("identity", 5, 1000, -500, 1000, -500);
        @(posedge clk_i);
        #1;
        directed("minus_j", 384, 1000, 0, 0, -1000);
        @(posedge clk_i);
        #1;
        directed("saturate", 640, -(64'sd1 <<< 24), -(64'sd1 <<< 24), -(64'sd1 <<< 24), 0);

        // Two full frames plus a little, counter wrapping 1023 -> 0.
        for (int i = 0; i < 2 * N + 16; i++) send(1'b1, i % N, rnd_data(), rnd_data());
        repeat (6) send(1'b0, 0, rnd_data(), rnd_data());

        gaps = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        cnt  = 100;
        for (int i = 0; i < 7; i++) begin
            send(gaps[i], cnt, rnd_data(), rnd_data());
            cnt = cnt + 37;
        end
        repeat (6) send(1'b0, 0, rnd_data(), rnd_data());

        // Reset with three samples in flight, asserted between clock edges.
        for (int i = 0; i < 3; i++) send(1'b1, 700 + i, rnd_data(), rnd_data());
        valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", longint'(valid_o), 0);
        chk("async_rst_cnt", longint'(cnt_o), 0);
        chk("async_rst_re", longint'(z_re_o), 0);
        chk("async_rst_im", longint'(z_im_o), 0);
        @(posedge clk_i);
        #3 rst_n = 1'b1;
        nval = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (valid_o) nval++;
        end
        chk("no_stale_sample", nval, 0);

        // Stream resumes cleanly after reset.
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 40; i++) send(($urandom_range(0, 3) != 0), 1000 + i, rnd_data(),
                                          rnd_data());
        repeat (6) send(1'b0, 0, rnd_data(), rnd_data());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_r22sdf_tw_mult.md
Name: fft_r22sdf_tw_mult

Overview:
- Twiddle-factor multiplier between two R2²SDF butterfly stages.
- Consumes the complex output and running counter of butterfly stage STAGE, and multiplies each sample by the stage twiddle W_L^e.
- Forwards the product and an aligned counter to the butterfly of stage STAGE+1.
- Twiddles come from a synchronous ROM indexed by the counter.

Parameters:
DATA_WIDTH, 25, signed width of each real/imag data component
TW_WIDTH, 25, signed twiddle component width, format Q1.(TW_WIDTH-2)
FFT_N, 1024, transform length
FFT_NLOG2, 10, log2(FFT_N)
STAGE, 0, index of upstream butterfly stage; must satisfy STAGE < STAGES-1
STAGES, 5, total butterfly stages (FFT_NLOG2/2)

Ports:
clk_i  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
valid_i  input  1  x_*_i and cnt_i carry a sample this cycle
cnt_i  input  FFT_NLOG2  sample counter from upstream butterfly cnt_o
x_re_i  input  DATA_WIDTH  signed real input
x_im_i  input  DATA_WIDTH  signed imag input
valid_o  output  1  z_*_o and cnt_o valid
cnt_o  output  FFT_NLOG2  cnt_i delayed to align with z_*_o
z_re_o  output  DATA_WIDTH  signed real product
z_im_o  output  DATA_WIDTH  signed imag product

Behaviour:
- Reset: rst_n low asynchronously clears every pipeline register. valid_o=0, cnt_o=0, z_re_o=0, z_im_o=0. Reset mid-stream discards all in-flight samples; no sample emerges until valid_i is asserted after release.
- Local size L = 2^(FFT_NLOG2-2*STAGE), LW = log2 L.
- Index fields:
  - b = cnt_i[LW-1:LW-2]
  - m = cnt_i[LW-3:0]
  - br(b) maps 0→0, 1→2, 2→1, 3→3
  - exponent e = m*br(b), width LW; max 3*(L/4-1) < L, so no wrap.
- Twiddle: W_L^e with re = round(cos(2πe/L)·2^(TW_WIDTH-2)) and im = -round(sin(2πe/L)·2^(TW_WIDTH-2)), round half away from zero. e=0 gives (2^(TW_WIDTH-2), 0).
- Pipeline, fixed latency 4 cycles, fully pipelined, one sample per cycle, no back-pressure:
  - P1: register e, x, cnt_i, valid_i.
  - P2: ROM synchronous read of W(e); register x, cnt, valid alongside.
  - P3: register the four products xr·wr, xi·wi, xr·wi, xi·wr, each DATA_WIDTH+TW_WIDTH bits.
  - P4:
    - re = xr·wr − xi·wi and im = xr·wi + xi·wr, each DATA_WIDTH+TW_WIDTH+1 bits.
    - Add 2^(TW_WIDTH-3), then arithmetic shift right by TW_WIDTH-2.
    - Saturate to [−2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)−1]; register to outputs.
- Valid handling:
  - valid_o equals valid_i delayed 4 cycles.
  - cnt_o equals cnt_i delayed 4 cycles.
  - Data registers load only when the corresponding stage valid is high. Outputs hold their last value while valid_o=0.
  - Gaps in valid_i are allowed; back-to-back samples are allowed.
- Counter wrap: cnt_i wraps FFT_N−1→0 naturally. Twiddle depends only on the low LW bits, so consecutive frames need no special handling.
- Elaboration: STAGE ≥ STAGES−1 (all twiddles unity) is a configuration error; fail via generate-time check.

Decomposition:
- Shared package fft_r22sdf_pkg holds:
  - function br2 (2-bit bit reversal)
  - function clog2
  - localparam helpers for L/LW per stage
  - rounding/saturation function sat_round(value, shift, width)
- Sub-module fft_r22sdf_tw_rom:
  - Parameters L, TW_WIDTH.
  - Ports clk_i, rst_n, addr_i[LW-1:0], tw_re_o, tw_im_o.
  - Registered output, contents computed at elaboration with $cos/$sin in an initial loop.

Test Plan:
- Identity (STAGE=0, STAGES=5): valid_i=1, cnt_i=5 (b=0, e=0), x=(1000,−500) → 4 cycles later valid_o=1, cnt_o=5, z=(1000,−500).
- −j rotation: cnt_i=384 (b=1, m=128, e=256), x=(1000,0) → z=(0,−1000).
- Saturation: cnt_i=640 (b=2, m=128, e=128, W≈(0.7071,−0.7071)), x=(−2^24,−2^24) → z_re=−2^24 (saturated), z_im=0.
- Streaming: 1024 consecutive random samples with cnt 0..1023, then wrap into a second frame → every output matches a double-precision reference within ±1 LSB; cnt_o sequence is continuous through 1023→0.
- Valid gaps: valid_i pattern 1,0,0,1,1,0,1 → valid_o reproduces the pattern shifted 4 cycles; z holds its value during valid_o=0.
- Reset mid-stream: assert rst_n=0 asynchronously between clock edges while 3 samples are in flight → outputs zero immediately. After release with valid_i=0, valid_o stays 0; no stale sample appears.
